// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier (unpack/exp-sum, mantissa product, normalise/round/pack)
// with a valid/ready handshake; denormal inputs read as zero and tiny results flush to zero.
module fp_mul_pipe #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] X,
   input  logic [W-1:0] Y,
   input  logic [1:0]   R_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] Z,
   output logic         invalid_flagex,
   output logic         overflow_flagex,
   output logic         underflow_flagex,
   output logic         inexact_flagex,
   output logic         zero_flagex
);
   localparam int STAGES = 3;
   localparam int EW     = EXP_W + 2;
   localparam int MW     = MAN_W + 1;
   localparam int PW     = 2 * MW;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W-1:0] EXP_FIN  = EXP_ONES - EXP_W'(1);
   localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic [1:0] RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RUP = 2'b10, RM_RDN = 2'b11;

   typedef enum logic [1:0] {CL_NUM, CL_ZERO, CL_INF, CL_NAN} cls_e;

   logic              en;
   logic [STAGES:1]   vld_pipe_d, vld_pipe_q;

   // The whole pipe moves in lockstep; it only freezes when the output is full and unaccepted.
   assign en         = !vld_pipe_q[STAGES] | out_ready;
   assign in_ready   = en;
   assign out_valid  = vld_pipe_q[STAGES];
   assign vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};

   // ---------------- stage 1: unpack / classify ----------------
   logic             x_sgn, y_sgn;
   logic [EXP_W-1:0] x_exp, y_exp;
   logic [MAN_W-1:0] x_man, y_man;
   logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;

   logic             s1_sgn_d, s1_sgn_q;
   cls_e             s1_cls_d, s1_cls_q;
   logic             s1_inv_d, s1_inv_q;
   logic [EW-1:0]    s1_exp_d, s1_exp_q;
   logic [MW-1:0]    s1_ma_d, s1_ma_q, s1_mb_d, s1_mb_q;
   logic [1:0]       s1_rm_d, s1_rm_q;

   always_comb begin
      {x_sgn, x_exp, x_man} = X;
      {y_sgn, y_exp, y_man} = Y;
      x_zero = (x_exp == '0);
      y_zero = (y_exp == '0);
      x_inf  = (x_exp == EXP_ONES) && (x_man == '0);
      y_inf  = (y_exp == EXP_ONES) && (y_man == '0);
      x_nan  = (x_exp == EXP_ONES) && (x_man != '0);
      y_nan  = (y_exp == EXP_ONES) && (y_man != '0);
      x_snan = x_nan && !x_man[MAN_W-1];
      y_snan = y_nan && !y_man[MAN_W-1];

      s1_sgn_d = x_sgn ^ y_sgn;
      s1_inv_d = 1'b0;
      if (x_nan || y_nan) begin
         s1_cls_d = CL_NAN;
         s1_inv_d = x_snan || y_snan;
      end else if ((x_zero && y_inf) || (x_inf && y_zero)) begin
         s1_cls_d = CL_NAN;
         s1_inv_d = 1'b1;
      end else if (x_inf || y_inf) begin
         s1_cls_d = CL_INF;
      end else if (x_zero || y_zero) begin
         s1_cls_d = CL_ZERO;
      end else begin
         s1_cls_d = CL_NUM;
      end
      s1_exp_d = EW'(x_exp) + EW'(y_exp) - BIAS;
      s1_ma_d  = {1'b1, x_man};
      s1_mb_d  = {1'b1, y_man};
      s1_rm_d  = R_mode;
   end

   // ---------------- stage 2: mantissa product ----------------
   logic          s2_sgn_d, s2_sgn_q;
   cls_e          s2_cls_d, s2_cls_q;
   logic          s2_inv_d, s2_inv_q;
   logic [EW-1:0] s2_exp_d, s2_exp_q;
   logic [PW-1:0] s2_prod_d, s2_prod_q;
   logic [1:0]    s2_rm_d, s2_rm_q;

   always_comb begin
      s2_sgn_d  = s1_sgn_q;
      s2_cls_d  = s1_cls_q;
      s2_inv_d  = s1_inv_q;
      s2_exp_d  = s1_exp_q;
      s2_rm_d   = s1_rm_q;
      s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
   end

   // ---------------- stage 3: normalise / round / pack ----------------
   logic [MAN_W-1:0] nrm_man;
   logic             grd, stk, rnd_inc, ovf_hit, unf_hit, to_inf;
   logic [EW-1:0]    nrm_exp, fin_exp;
   logic [MW-1:0]    rnd_man;

   logic [W-1:0]     z_d, z_q;
   logic             inv_d, inv_q, ovf_d, ovf_q, unf_d, unf_q, inx_d, inx_q, zro_d, zro_q;

   always_comb begin
      if (s2_prod_q[PW-1]) begin
         nrm_man = s2_prod_q[PW-2 -: MAN_W];
         grd     = s2_prod_q[MAN_W];
         stk     = |s2_prod_q[MAN_W-1:0];
         nrm_exp = s2_exp_q + EW'(1);
      end else begin
         nrm_man = s2_prod_q[PW-3 -: MAN_W];
         grd     = s2_prod_q[MAN_W-1];
         stk     = |s2_prod_q[MAN_W-2:0];
         nrm_exp = s2_exp_q;
      end

      case (s2_rm_q)
         RM_RNE:  rnd_inc = grd & (stk | nrm_man[0]);
         RM_RTZ:  rnd_inc = 1'b0;
         RM_RUP:  rnd_inc = !s2_sgn_q & (grd | stk);
         RM_RDN:  rnd_inc = s2_sgn_q & (grd | stk);
         default: rnd_inc = 1'b0;
      endcase

      // A carry out of the mantissa leaves the low bits at zero, so only the exponent moves.
      rnd_man = {1'b0, nrm_man} + MW'(rnd_inc);
      fin_exp = nrm_exp + EW'(rnd_man[MAN_W]);
      ovf_hit = $signed(fin_exp) >= $signed(EXP_MAX);
      unf_hit = fin_exp[EW-1] | (fin_exp == '0);
      to_inf  = (s2_rm_q == RM_RNE) | ((s2_rm_q == RM_RUP) & !s2_sgn_q) |
                ((s2_rm_q == RM_RDN) & s2_sgn_q);

      z_d   = '0;
      inv_d = 1'b0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;
      zro_d = 1'b0;
      case (s2_cls_q)
         CL_NAN: begin
            z_d   = {1'b0, EXP_ONES, {MAN_W{1'b1}}};
            inv_d = s2_inv_q;
         end
         CL_INF: z_d = {s2_sgn_q, EXP_ONES, {MAN_W{1'b0}}};
         CL_ZERO: begin
            z_d   = {s2_sgn_q, {(W-1){1'b0}}};
            zro_d = 1'b1;
         end
         default: begin
            if (ovf_hit) begin
               z_d   = to_inf ? {s2_sgn_q, EXP_ONES, {MAN_W{1'b0}}}
                              : {s2_sgn_q, EXP_FIN, {MAN_W{1'b1}}};
               ovf_d = 1'b1;
               inx_d = 1'b1;
            end else if (unf_hit) begin
               z_d   = {s2_sgn_q, {(W-1){1'b0}}};
               unf_d = 1'b1;
               inx_d = 1'b1;
               zro_d = 1'b1;
            end else begin
               z_d   = {s2_sgn_q, fin_exp[EXP_W-1:0], rnd_man[MAN_W-1:0]};
               inx_d = grd | stk;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_pipe_q <= '0;
         s1_sgn_q   <= 1'b0;
         s1_cls_q   <= CL_NUM;
         s1_inv_q   <= 1'b0;
         s1_exp_q   <= '0;
         s1_ma_q    <= '0;
         s1_mb_q    <= '0;
         s1_rm_q    <= '0;
         s2_sgn_q   <= 1'b0;
         s2_cls_q   <= CL_NUM;
         s2_inv_q   <= 1'b0;
         s2_exp_q   <= '0;
         s2_prod_q  <= '0;
         s2_rm_q    <= '0;
         z_q        <= '0;
         inv_q      <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         inx_q      <= 1'b0;
         zro_q      <= 1'b0;
      end else if (en) begin
         vld_pipe_q <= vld_pipe_d;
         s1_sgn_q   <= s1_sgn_d;
         s1_cls_q   <= s1_cls_d;
         s1_inv_q   <= s1_inv_d;
         s1_exp_q   <= s1_exp_d;
         s1_ma_q    <= s1_ma_d;
         s1_mb_q    <= s1_mb_d;
         s1_rm_q    <= s1_rm_d;
         s2_sgn_q   <= s2_sgn_d;
         s2_cls_q   <= s2_cls_d;
         s2_inv_q   <= s2_inv_d;
         s2_exp_q   <= s2_exp_d;
         s2_prod_q  <= s2_prod_d;
         s2_rm_q    <= s2_rm_d;
         z_q        <= z_d;
         inv_q      <= inv_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         inx_q      <= inx_d;
         zro_q      <= zro_d;
      end
   end

   assign Z                = z_q;
   assign invalid_flagex   = inv_q;
   assign overflow_flagex  = ovf_q;
   assign underflow_flagex = unf_q;
   assign inexact_flagex   = inx_q;
   assign zero_flagex      = zro_q;

endmodule
